alu_rs_station: RTL

ALU reservation station: the initiator/consumer end of the ALU common-data-bus (CDB) handshake.
- Accepts decoded ALU ops from the issue stage and holds them until both operands are available.
- Snoops CDB broadcasts (tag/data) to wake waiting operands.
- Dispatches one ready op per cycle to the ALU, tagged with its station slot number.
- Frees a slot only when the CDB returns a finish pulse carrying that slot number.

---
 rtl/alu_rs_station.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_rs_station.sv
// ALU reservation station: holds decoded ALU ops until both operands are
// available, wakes operands from CDB broadcasts, dispatches one ready op per
// cycle and releases a slot when the CDB reports that slot's completion.
module alu_rs_station #(
    parameter int unsigned      ENTRIES  = 4,
    parameter int unsigned      RS_W     = 2,
    parameter int unsigned      TAG_W    = 4,
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      OP_W     = 5,
    parameter logic [TAG_W-1:0] TAG_FREE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_dest,
    output logic              full,
    input  logic              cdb_finish,
    input  logic [RS_W-1:0]   cdb_rs_num,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              alu_valid,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [TAG_W-1:0]  alu_dest,
    output logic [RS_W-1:0]   alu_rs_num
);

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ISSD = 2'd2;

    logic [1:0]        st_q   [ENTRIES];
    logic [1:0]        st_d   [ENTRIES];
    logic [OP_W-1:0]   op_q   [ENTRIES];
    logic [OP_W-1:0]   op_d   [ENTRIES];
    logic [TAG_W-1:0]  qj_q   [ENTRIES];
    logic [TAG_W-1:0]  qj_d   [ENTRIES];
    logic [TAG_W-1:0]  qk_q   [ENTRIES];
    logic [TAG_W-1:0]  qk_d   [ENTRIES];
    logic [DATA_W-1:0] vj_q   [ENTRIES];
    logic [DATA_W-1:0] vj_d   [ENTRIES];
    logic [DATA_W-1:0] vk_q   [ENTRIES];
    logic [DATA_W-1:0] vk_d   [ENTRIES];
    logic [TAG_W-1:0]  dest_q [ENTRIES];
    logic [TAG_W-1:0]  dest_d [ENTRIES];

    logic              alu_valid_q, alu_valid_d;
    logic [OP_W-1:0]   alu_op_q,    alu_op_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [TAG_W-1:0]  alu_dest_q,  alu_dest_d;
    logic [RS_W-1:0]   alu_rs_q,    alu_rs_d;

    logic              free_found;
    logic [RS_W-1:0]   alloc_idx;
    logic              disp_found;
    logic [RS_W-1:0]   disp_idx;
    logic              cdb_hit;

    assign cdb_hit = (cdb_tag != TAG_FREE);

    // Lowest-index free slot and lowest-index ready pending slot, from current state
    always_comb begin
        free_found = 1'b0;
        alloc_idx  = '0;
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!free_found && st_q[i] == ST_FREE) begin
                free_found = 1'b1;
                alloc_idx  = RS_W'(i);
            end
            if (!disp_found && st_q[i] == ST_PEND &&
                qj_q[i] == TAG_FREE && qk_q[i] == TAG_FREE) begin
                disp_found = 1'b1;
                disp_idx   = RS_W'(i);
            end
        end
    end

    // Combinational by design: a slot freed this cycle is seen as free next cycle
    assign full = ~free_found;

    // Next state: wakeup, finish, dispatch and allocate touch disjoint slots
    always_comb begin
        st_d        = st_q;
        op_d        = op_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        dest_d      = dest_q;
        alu_valid_d = disp_found;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_dest_d  = alu_dest_q;
        alu_rs_d    = alu_rs_q;

        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (st_q[i] == ST_PEND && cdb_hit) begin
                if (qj_q[i] == cdb_tag) begin
                    qj_d[i] = TAG_FREE;
                    vj_d[i] = cdb_data;
                end
                if (qk_q[i] == cdb_tag) begin
                    qk_d[i] = TAG_FREE;
                    vk_d[i] = cdb_data;
                end
            end
            if (st_q[i] == ST_ISSD && cdb_finish && cdb_rs_num == RS_W'(i)) begin
                st_d[i] = ST_FREE;
            end
        end

        if (disp_found) begin
            st_d[disp_idx] = ST_ISSD;
            alu_op_d       = op_q[disp_idx];
            alu_a_d        = vj_q[disp_idx];
            alu_b_d        = vk_q[disp_idx];
            alu_dest_d     = dest_q[disp_idx];
            alu_rs_d       = disp_idx;
        end

        // Operands produced by this cycle's broadcast are captured directly
        if (issue_valid && free_found) begin
            st_d[alloc_idx]   = ST_PEND;
            op_d[alloc_idx]   = issue_op;
            dest_d[alloc_idx] = issue_dest;
            if (cdb_hit && issue_qj == cdb_tag) begin
                qj_d[alloc_idx] = TAG_FREE;
                vj_d[alloc_idx] = cdb_data;
            end else begin
                qj_d[alloc_idx] = issue_qj;
                vj_d[alloc_idx] = issue_vj;
            end
            if (cdb_hit && issue_qk == cdb_tag) begin
                qk_d[alloc_idx] = TAG_FREE;
                vk_d[alloc_idx] = cdb_data;
            end else begin
                qk_d[alloc_idx] = issue_qk;
                vk_d[alloc_idx] = issue_vk;
            end
        end
    end

    // State and output registers; reset drops every in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                st_q[i]   <= ST_FREE;
                op_q[i]   <= '0;
                qj_q[i]   <= TAG_FREE;
                qk_q[i]   <= TAG_FREE;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                dest_q[i] <= TAG_FREE;
            end
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_dest_q  <= TAG_FREE;
            alu_rs_q    <= '0;
        end else begin
            st_q        <= st_d;
            op_q        <= op_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            dest_q      <= dest_d;
            alu_valid_q <= alu_valid_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_dest_q  <= alu_dest_d;
            alu_rs_q    <= alu_rs_d;
        end
    end

    assign alu_valid  = alu_valid_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_dest   = alu_dest_q;
    assign alu_rs_num = alu_rs_q;

endmodule
